// File: rtl/bram_dump_sequencer.sv
// bram_dump_sequencer: copies a window of the result BRAM into the output memory when the run register is set.
module bram_dump_sequencer #(
  parameter int MEM_ADDR_WIDTH       = 13,
  parameter int OUTMEM_ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH           = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            userRunValue,
  output logic                            userRunClear,
  output logic                            register32CmdReq,
  input  logic                            register32CmdAck,
  output logic [7:0]                      register32Address,
  input  logic                            register32ReadDataValid,
  input  logic [31:0]                     register32ReadData,
  output logic                            memReadEn,
  output logic [MEM_ADDR_WIDTH-1:0]       memReadAddr,
  input  logic [DATA_WIDTH-1:0]           memReadData,
  output logic                            outputMemoryWriteReq,
  input  logic                            outputMemoryWriteAck,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
  output logic [DATA_WIDTH-1:0]           outputMemoryWriteData,
  output logic                            busy
);
  localparam int CW = OUTMEM_ADDRESS_WIDTH + 1;
  localparam logic [31:0] MAX_CNT = 32'd1 << OUTMEM_ADDRESS_WIDTH;
  typedef enum logic [2:0] {IDLE, P_REQ, P_WAIT, RD, CAP, WR, CLEAR} state_t;
  state_t                            state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0]         start_q, start_d, rd_addr_q, rd_addr_d;
  logic [CW-1:0]                     count_q, count_d, idx_q, idx_d, idx_inc, cnt;
  logic                              req_q, req_d, addr_q, addr_d, rd_en_q, rd_en_d;
  logic                              wr_req_q, wr_req_d, clr_q, clr_d;
  logic [OUTMEM_ADDRESS_WIDTH-1:0]   wr_add_q, wr_add_d;
  logic [DATA_WIDTH-1:0]             wr_data_q, wr_data_d;
  assign idx_inc = idx_q + CW'(1);
  assign cnt = (register32ReadData >= MAX_CNT) ? CW'(MAX_CNT) : CW'(register32ReadData);
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    count_d   = count_q;
    idx_d     = idx_q;
    req_d     = req_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_req_d  = wr_req_q;
    wr_add_d  = wr_add_q;
    wr_data_d = wr_data_q;
    clr_d     = 1'b0;
    case (state_q)
      IDLE: if (userRunValue && !clr_q) begin
        req_d   = 1'b1;
        addr_d  = 1'b0;
        state_d = P_REQ;
      end
      P_REQ: if (req_q && register32CmdAck) begin
        req_d   = 1'b0;
        state_d = P_WAIT;
      end
      P_WAIT: if (register32ReadDataValid) begin
        if (!addr_q) begin
          start_d = register32ReadData[MEM_ADDR_WIDTH-1:0];
          addr_d  = 1'b1;
          req_d   = 1'b1;
          state_d = P_REQ;
        end else begin
          count_d   = cnt;
          idx_d     = '0;
          clr_d     = cnt == '0;
          rd_en_d   = cnt != '0;
          rd_addr_d = start_q;
          state_d   = (cnt == '0) ? CLEAR : RD;
        end
      end
      RD: state_d = CAP;
      CAP: begin
        wr_data_d = memReadData;
        wr_add_d  = idx_q[OUTMEM_ADDRESS_WIDTH-1:0];
        wr_req_d  = 1'b1;
        state_d   = WR;
      end
      // idx_inc == count marks the last word of the window
      WR: if (wr_req_q && outputMemoryWriteAck) begin
        wr_req_d = 1'b0;
        if (idx_inc == count_q) begin
          clr_d   = 1'b1;
          state_d = CLEAR;
        end else begin
          idx_d     = idx_inc;
          rd_en_d   = 1'b1;
          rd_addr_d = start_q + MEM_ADDR_WIDTH'(idx_inc);
          state_d   = RD;
        end
      end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_req_q  <= wr_req_d;
      wr_add_q  <= wr_add_d;
      wr_data_q <= wr_data_d;
      clr_q     <= clr_d;
    end
  end
  assign userRunClear          = clr_q;
  assign register32CmdReq      = req_q;
  assign register32Address     = 8'(addr_q);
  assign memReadEn             = rd_en_q;
  assign memReadAddr           = rd_addr_q;
  assign outputMemoryWriteReq  = wr_req_q;
  assign outputMemoryWriteAdd  = wr_add_q;
  assign outputMemoryWriteData = wr_data_q;
  assign busy                  = state_q != IDLE;
endmodule

// File: tb/tb_bram_dump_sequencer.sv
// tb_bram_dump_sequencer: randomized scoreboard bench; expected writes come from the window arithmetic on a BRAM image.
module tb_bram_dump_sequencer;
  logic        clk, reset;
  logic        userRunValue, userRunClear;
  logic        register32CmdReq, register32CmdAck;
  logic [7:0]  register32Address;
  logic        register32ReadDataValid;
  logic [31:0] register32ReadData;
  logic        memReadEn;
  logic [12:0] memReadAddr;
  logic [7:0]  memReadData;
  logic        outputMemoryWriteReq, outputMemoryWriteAck;
  logic [12:0] outputMemoryWriteAdd;
  logic [7:0]  outputMemoryWriteData;
  logic        busy;

  bram_dump_sequencer dut (
    .clk(clk), .reset(reset),
    .userRunValue(userRunValue), .userRunClear(userRunClear),
    .register32CmdReq(register32CmdReq), .register32CmdAck(register32CmdAck),
    .register32Address(register32Address),
    .register32ReadDataValid(register32ReadDataValid), .register32ReadData(register32ReadData),
    .memReadEn(memReadEn), .memReadAddr(memReadAddr), .memReadData(memReadData),
    .outputMemoryWriteReq(outputMemoryWriteReq), .outputMemoryWriteAck(outputMemoryWriteAck),
    .outputMemoryWriteAdd(outputMemoryWriteAdd), .outputMemoryWriteData(outputMemoryWriteData),
    .busy(busy)
  );

  typedef struct {
    logic [12:0] add;
    logic [7:0]  data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  bram [8192];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, launch_cnt = 0, seen_launch = 0;
  int          clears = 0, reads = 0, writes = 0;
  int          clr_cyc = 0, last_valid_cyc = 0, last_acc_cyc = 0;
  int          stalled = 0, stall_idx = -1, stall_len = 10;
  bit          ack_rand = 0, drop_run = 0, last_acc_valid = 0;
  logic [31:0] p0 = 0, p1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) memReadData <= memReadEn ? bram[memReadAddr] : 8'($urandom);

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Environment: run register, parameter responder, write-port acker and scoreboard monitor.
  initial begin
    int          pend;
    logic [31:0] pdata;
    bit          prev_wr, accept;
    logic [12:0] prev_add;
    logic [7:0]  prev_data;
    exp_t        e;
    pend = 0; pdata = 0; prev_wr = 0; prev_add = 0; prev_data = 0;
    userRunValue = 0; register32CmdAck = 0; register32ReadDataValid = 0;
    register32ReadData = 0; outputMemoryWriteAck = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        userRunValue = 0; register32CmdAck = 0; register32ReadDataValid = 0;
        outputMemoryWriteAck = 0; pend = 0; prev_wr = 0;
      end else begin
        if (launch_cnt != seen_launch) begin
          seen_launch = launch_cnt; userRunValue = 1; stalled = 0; last_acc_valid = 0;
        end
        if (userRunClear) begin
          userRunValue = 0; clears++; clr_cyc = cyc;
        end
        if (drop_run && register32CmdReq) userRunValue = 0;
        register32ReadDataValid = 0;
        register32ReadData = $urandom;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            register32ReadDataValid = 1; register32ReadData = pdata; last_valid_cyc = cyc;
          end
        end else if (outputMemoryWriteReq && $urandom_range(3) == 0)
          register32ReadDataValid = 1;
        register32CmdAck = ack_rand ? 1'($urandom_range(1)) : 1'b1;
        if (register32CmdReq && register32CmdAck) begin
          pend = $urandom_range(1, 3);
          pdata = (register32Address == 8'd0) ? p0 : (register32Address == 8'd1) ? p1 : 32'hDEAD_BEEF;
        end
        if (memReadEn) reads++;
        if (outputMemoryWriteReq && int'(outputMemoryWriteAdd) == stall_idx && stalled < stall_len) begin
          outputMemoryWriteAck = 0; stalled++;
        end else outputMemoryWriteAck = ack_rand ? 1'($urandom_range(1)) : 1'b1;
        if (prev_wr) begin
          chk("wr_req_held", outputMemoryWriteReq, 1);
          chk("wr_add_stable", outputMemoryWriteAdd, prev_add);
          chk("wr_data_stable", outputMemoryWriteData, prev_data);
        end
        accept = outputMemoryWriteReq && outputMemoryWriteAck;
        if (accept) begin
          writes++;
          chk("sb_nonempty", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("wr_add", outputMemoryWriteAdd, e.add);
            chk("wr_data", outputMemoryWriteData, e.data);
          end
          if (!ack_rand && stall_idx < 0 && last_acc_valid) chk("throughput", cyc - last_acc_cyc, 3);
          last_acc_cyc = cyc; last_acc_valid = 1;
        end
        prev_wr = outputMemoryWriteReq && !accept;
        prev_add = outputMemoryWriteAdd;
        prev_data = outputMemoryWriteData;
      end
    end
  end

  task automatic check_outputs_zero(string tag);
    chk({tag, "_run_clear"}, userRunClear, 0);
    chk({tag, "_cmd_req"}, register32CmdReq, 0);
    chk({tag, "_reg_addr"}, register32Address, 0);
    chk({tag, "_rd_en"}, memReadEn, 0);
    chk({tag, "_rd_addr"}, memReadAddr, 0);
    chk({tag, "_wr_req"}, outputMemoryWriteReq, 0);
    chk({tag, "_wr_add"}, outputMemoryWriteAdd, 0);
    chk({tag, "_wr_data"}, outputMemoryWriteData, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic load(input logic [12:0] st, input logic [31:0] len, input bit ar, input int si, input bit dr, output int n);
    n = (len > 32'd8192) ? 8192 : int'(len);
    p0 = ($urandom() & 32'hFFFF_E000) | 32'(st);
    p1 = len; ack_rand = ar; stall_idx = si; drop_run = dr;
    for (int i = 0; i < n; i++) q.push_back('{add: 13'(i), data: bram[(int'(st) + i) % 8192]});
  endtask

  task automatic run(input logic [12:0] st, input logic [31:0] len, input bit ar, input int si, input bit dr);
    int n, r0, w0, c0, budget;
    load(st, len, ar, si, dr, n);
    r0 = reads; w0 = writes; c0 = clears;
    launch_cnt++;
    budget = n * 12 + 300;
    for (int i = 0; i < budget && clears == c0; i++) @(negedge clk);
    chk("run_complete", clears != c0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("busy_idle", busy, 0);
    chk("clear_pulses", clears - c0, 1);
    chk("read_count", reads - r0, n);
    chk("write_count", writes - w0, n);
    chk("sb_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int  n;
    bit  found;
    for (int i = 0; i < 8192; i++) bram[i] = 8'($urandom);
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 0;
    run(13'd5, 32'd4, 0, -1, 0);
    run(13'd8190, 32'd4, 0, -1, 0);
    run(13'd77, 32'd0, 0, -1, 0);
    chk("clear_latency", clr_cyc - last_valid_cyc, 1);
    run(13'd100, 32'hFFFF_FFFF, 0, -1, 0);
    run(13'd30, 32'd6, 0, 2, 0);
    chk("stall_cycles", stalled, 10);
    for (int k = 0; k < 6; k++)
      run(13'($urandom_range(8191)), 32'($urandom_range(1, 40)), 1, -1, k == 2);
    stall_len = 1000;
    load(13'd200, 32'd10, 0, 3, 0, n);
    launch_cnt++;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      if (outputMemoryWriteReq && outputMemoryWriteAdd == 13'd3) found = 1;
    end
    chk("reached_wr3", found, 1);
    #1 reset = 1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    q.delete();
    stall_len = 10;
    run(13'd7, 32'd5, 1, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
